// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD command/symbol sequencer: state encoding,
// entry field positions and the end-of-sequence marker.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DELAY,
    ST_VALID,
    ST_DONE
  } seq_state_t;

  // A ROM entry is {delay, data}; the data field sits in the low bits.
  localparam int unsigned DATA_LSB   = 0;
  localparam int unsigned END_MARKER = 0;

  function automatic int unsigned dly_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Delay-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable so
// the first tick after a restart lands exactly TICK_DIV cycles later.
module lcd_tick_gen #(
  parameter int TICK_DIV = 131072
) (
  input  logic clk_i,
  input  logic restn_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge restn_i) begin
    if (!restn_i) begin
      cnt <= '0;
    end else if (restart_i || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = !restart_i && (cnt == LAST);

endmodule

// File: rtl/lcd_seq_engine.sv
// Sequencer that walks {delay, data} ROM entries from a base address, waits
// each delay in prescaled ticks and hands the data to the LCD write controller.
module lcd_seq_engine
  import lcd_seq_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int DLY_W    = 4,
  parameter int ADDR_W   = 6,
  parameter int TICK_DIV = 131072,
  parameter int ROM_LAT  = 1
) (
  input  logic                    clk_i,
  input  logic                    restn_i,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       base_addr_i,
  input  logic                    loop_i,
  input  logic                    abort_i,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [DLY_W+DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    data_valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int DLY_LSB = dly_lsb(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [1:0]        LAT_LAST  = 2'(ROM_LAT);
  localparam logic [DATA_W-1:0] END_DATA  = DATA_W'(END_MARKER);

  seq_state_t        state, nxt_state;
  logic [1:0]        lat_cnt, nxt_lat_cnt;
  logic [DLY_W-1:0]  dly_q, nxt_dly;
  logic [DLY_W-1:0]  dly_cnt, nxt_dly_cnt;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_valid, nxt_busy, nxt_done;
  logic              tick, tick_restart, transfer;
  logic [DATA_W-1:0] rom_data_f;
  logic [DLY_W-1:0]  rom_dly_f;

  assign rom_data_f   = rom_data_i[DATA_LSB +: DATA_W];
  assign rom_dly_f    = rom_data_i[DLY_LSB +: DLY_W];
  assign transfer     = data_valid_o && ready_i;
  assign tick_restart = (state != ST_DELAY);

  lcd_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk_i    (clk_i),
    .restn_i  (restn_i),
    .restart_i(tick_restart),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or negedge restn_i) begin
    if (!restn_i) begin
      state        <= ST_IDLE;
      lat_cnt      <= '0;
      dly_q        <= '0;
      dly_cnt      <= '0;
      rom_addr_o   <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state        <= nxt_state;
      lat_cnt      <= nxt_lat_cnt;
      dly_q        <= nxt_dly;
      dly_cnt      <= nxt_dly_cnt;
      rom_addr_o   <= nxt_addr;
      data_o       <= nxt_data;
      data_valid_o <= nxt_valid;
      busy_o       <= nxt_busy;
      done_o       <= nxt_done;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_lat_cnt = lat_cnt;
    nxt_dly     = dly_q;
    nxt_dly_cnt = dly_cnt;
    nxt_addr    = rom_addr_o;
    nxt_data    = data_o;
    nxt_valid   = data_valid_o;
    nxt_done    = 1'b0;

    if (abort_i) begin
      nxt_state = ST_IDLE;
      nxt_valid = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            nxt_addr    = base_addr_i;
            nxt_lat_cnt = '0;
            nxt_state   = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (lat_cnt != LAT_LAST) begin
            nxt_lat_cnt = lat_cnt + 2'd1;
          end else if (rom_data_f == END_DATA) begin
            if (loop_i) begin
              nxt_addr    = base_addr_i;
              nxt_lat_cnt = '0;
            end else begin
              nxt_state = ST_DONE;
              nxt_done  = 1'b1;
            end
          end else begin
            // Zero-delay entries bypass DELAY so data is offered the cycle after latching.
            nxt_data    = rom_data_f;
            nxt_dly     = rom_dly_f;
            nxt_dly_cnt = '0;
            if (rom_dly_f == '0) begin
              nxt_state = ST_VALID;
              nxt_valid = 1'b1;
            end else begin
              nxt_state = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (dly_cnt >= dly_q) begin
            nxt_state = ST_VALID;
            nxt_valid = 1'b1;
          end else if (tick) begin
            nxt_dly_cnt = dly_cnt + 1'b1;
          end
        end
        ST_VALID: begin
          if (transfer) begin
            nxt_valid = 1'b0;
            // The top address never wraps; it ends the sequence like a marker.
            if (rom_addr_o != LAST_ADDR) begin
              nxt_addr    = rom_addr_o + 1'b1;
              nxt_lat_cnt = '0;
              nxt_state   = ST_FETCH;
            end else if (loop_i) begin
              nxt_addr    = base_addr_i;
              nxt_lat_cnt = '0;
              nxt_state   = ST_FETCH;
            end else begin
              nxt_state = ST_DONE;
              nxt_done  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          nxt_state = ST_IDLE;
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_valid = 1'b0;
        end
      endcase
    end

    nxt_busy = (nxt_state != ST_IDLE) && (nxt_state != ST_DONE);
  end

endmodule

// File: tb/tb_lcd_seq_engine.sv
// Self-checking bench for lcd_seq_engine: cycle table for the basic sequence,
// directed corner cases, and randomized ROM sequences against a transfer model.
module tb_lcd_seq_engine;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        restn_i, start_i, loop_i, abort_i, ready_i;
  logic [5:0]  base_addr_i;
  logic [5:0]  rom_addr, rom_addr2;
  logic [12:0] rom_q1, rom_q2a, rom_q2b;
  logic [8:0]  data, data2;
  logic        data_valid, data_valid2, busy, busy2, done, done2;
  logic [12:0] rom [64];

  typedef struct {
    int addr;
    int data;
  } xfer_t;

  typedef struct {
    logic       start;
    logic       ready;
    logic [5:0] addr;
    logic       valid;
    logic [8:0] data;
    logic       busy;
    logic       done;
    logic       chk_v2;
    logic       v2;
  } vec_t;

  xfer_t exp_q[$];
  vec_t  vecs[$];
  int    n_checks = 0, n_fail = 0;
  int    cyc = 0, fetch_cyc = 0, last_addr = -1;
  bit    mon_en = 0, prev_valid = 0, done_seen = 0;

  lcd_seq_engine #(.DATA_W(9), .DLY_W(4), .ADDR_W(6), .TICK_DIV(TD), .ROM_LAT(1)) dut (
    .clk_i(clk), .restn_i(restn_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .loop_i(loop_i), .abort_i(abort_i), .rom_addr_o(rom_addr), .rom_data_i(rom_q1),
    .data_o(data), .data_valid_o(data_valid), .ready_i(ready_i), .busy_o(busy), .done_o(done)
  );

  lcd_seq_engine #(.DATA_W(9), .DLY_W(4), .ADDR_W(6), .TICK_DIV(TD), .ROM_LAT(2)) dut2 (
    .clk_i(clk), .restn_i(restn_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .loop_i(loop_i), .abort_i(abort_i), .rom_addr_o(rom_addr2), .rom_data_i(rom_q2b),
    .data_o(data2), .data_valid_o(data_valid2), .ready_i(ready_i), .busy_o(busy2), .done_o(done2)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs with one and two cycles of read latency.
  always @(posedge clk) begin
    rom_q1  <= rom[rom_addr];
    rom_q2a <= rom[rom_addr2];
    rom_q2b <= rom_q2a;
  end

  function automatic logic [12:0] ent(input int d, input int dat);
    return {4'(d), 9'(dat)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected transfers: walk from base until a zero data field or the last address.
  task automatic buildExpected(input int base, input int passes);
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int a = base; a < 64; a++) begin
        if (rom[a][8:0] == 9'd0) break;
        exp_q.push_back('{a, int'(rom[a][8:0])});
      end
    end
  endtask

  task automatic monitorOutputs();
    int d;
    int lat;
    if (int'(rom_addr) != last_addr) begin
      last_addr = int'(rom_addr);
      fetch_cyc = cyc;
    end
    if (data_valid && !prev_valid) begin
      d   = int'(rom[rom_addr][12:9]);
      lat = 2 + ((d != 0) ? d * TD + 1 : 0);
      checkOutput("valid_latency", cyc - fetch_cyc, lat);
    end
    if (done) begin
      done_seen = 1;
      checkOutput("done_queue_empty", exp_q.size(), 0);
    end
    prev_valid = data_valid;
  endtask

  task automatic applyStimulus(input logic st, input logic [5:0] base, input logic lp,
                               input logic ab, input logic rdy);
    @(negedge clk);
    cyc++;
    if (mon_en) monitorOutputs();
    start_i = st; base_addr_i = base; loop_i = lp; abort_i = ab; ready_i = rdy;
    if (st) begin
      last_addr  = -1;
      prev_valid = 0;
    end
    if (mon_en && data_valid && rdy && !ab) begin
      if (exp_q.size() == 0) begin
        checkOutput("xfer_unexpected", data_valid, 0);
      end else begin
        checkOutput("xfer_data", data, exp_q[0].data);
        checkOutput("xfer_addr", rom_addr, exp_q[0].addr);
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic runUntilDone(input int base, input int pct, input int budget);
    int k = 0;
    mon_en = 1; done_seen = 0;
    applyStimulus(1, 6'(base), 0, 0, 1);
    while (!done_seen && k < budget) begin
      applyStimulus(0, 6'(base), 0, 0, ($urandom_range(0, 99) < pct));
      k++;
    end
    checkOutput("done_within_budget", done_seen, 1);
    checkOutput("all_xfers_seen", exp_q.size(), 0);
    applyStimulus(0, 6'(base), 0, 0, 1);
    applyStimulus(0, 6'(base), 0, 0, 1);
    mon_en = 0;
  endtask

  task automatic abortAll();
    mon_en = 0;
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic loadTest1();
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom[0] = ent(0, 'h038);
    rom[1] = ent(2, 'h00C);
    rom[2] = ent(0, 'h000);
  endtask

  task automatic addVec(input logic st, input logic [5:0] a, input logic v, input logic [8:0] d,
                        input logic b, input logic dn, input logic c2, input logic v2);
    vecs.push_back('{st, 1'b1, a, v, d, b, dn, c2, v2});
  endtask

  initial begin
    int k, first1, first2, base, len;
    restn_i = 0; start_i = 0; loop_i = 0; abort_i = 0; ready_i = 1; base_addr_i = 0;
    loadTest1();
    repeat (3) @(negedge clk);
    checkOutput("rst_addr", rom_addr, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_valid", data_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    restn_i = 1;

    // Basic one-shot sequence, checked every cycle.
    addVec(1, 0, 0, 'h000, 1, 0, 1, 0);
    addVec(0, 0, 0, 'h000, 1, 0, 1, 0);
    addVec(0, 0, 1, 'h038, 1, 0, 1, 0);
    addVec(0, 1, 0, 'h038, 1, 0, 1, 1);
    addVec(0, 1, 0, 'h038, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) addVec(0, 1, 0, 'h00C, 1, 0, 0, 0);
    addVec(0, 1, 1, 'h00C, 1, 0, 0, 0);
    addVec(0, 2, 0, 'h00C, 1, 0, 0, 0);
    addVec(0, 2, 0, 'h00C, 1, 0, 0, 0);
    addVec(0, 2, 0, 'h00C, 0, 1, 0, 0);
    addVec(0, 2, 0, 'h00C, 0, 0, 0, 0);
    addVec(0, 2, 0, 'h00C, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      start_i = vecs[i].start; ready_i = vecs[i].ready;
      @(negedge clk);
      checkOutput($sformatf("t1_addr[%0d]", i), rom_addr, vecs[i].addr);
      checkOutput($sformatf("t1_valid[%0d]", i), data_valid, vecs[i].valid);
      checkOutput($sformatf("t1_data[%0d]", i), data, vecs[i].data);
      checkOutput($sformatf("t1_busy[%0d]", i), busy, vecs[i].busy);
      checkOutput($sformatf("t1_done[%0d]", i), done, vecs[i].done);
      if (vecs[i].chk_v2) checkOutput($sformatf("t1_lat2_valid[%0d]", i), data_valid2, vecs[i].v2);
    end
    abortAll();

    // Backpressure: output held stable while ready is low.
    applyStimulus(1, 0, 0, 0, 0);
    k = 0;
    while (!data_valid && k < 10) begin applyStimulus(0, 0, 0, 0, 0); k++; end
    checkOutput("bp_reach_valid", data_valid, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("bp_valid", data_valid, 1);
      checkOutput("bp_data", data, 'h038);
      checkOutput("bp_addr", rom_addr, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bp_valid_drop", data_valid, 0);
    checkOutput("bp_addr_next", rom_addr, 1);
    abortAll();

    // Loop mode for two full passes, then one-shot ends the third.
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom[16] = ent(1, 'h101); rom[17] = ent(0, 'h0AA); rom[18] = ent(3, 'h155); rom[19] = ent(2, 0);
    buildExpected(16, 3);
    mon_en = 1; done_seen = 0;
    applyStimulus(1, 16, 1, 0, 1);
    k = 0;
    while (!done_seen && k < 1000) begin
      applyStimulus(0, 16, (exp_q.size() > 2), 0, 1);
      k++;
    end
    checkOutput("loop_done_seen", done_seen, 1);
    checkOutput("loop_all_xfers", exp_q.size(), 0);
    applyStimulus(0, 16, 0, 0, 1);
    mon_en = 0;
    abortAll();

    // Abort while waiting out a delay.
    loadTest1();
    applyStimulus(1, 0, 0, 0, 1);
    k = 0;
    while (rom_addr != 6'd1 && k < 20) begin applyStimulus(0, 0, 0, 0, 1); k++; end
    repeat (5) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ab_delay_busy", busy, 1);
    checkOutput("ab_delay_novalid", data_valid, 0);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ab_delay_idle_busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("ab_delay_no_valid", data_valid, 0);
      checkOutput("ab_delay_no_done", done, 0);
    end

    // Abort in VALID with ready high: abort wins, address does not advance.
    applyStimulus(1, 0, 0, 0, 0);
    k = 0;
    while (!data_valid && k < 10) begin applyStimulus(0, 0, 0, 0, 0); k++; end
    checkOutput("ab_valid_reached", data_valid, 1);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ab_valid_drop", data_valid, 0);
    checkOutput("ab_valid_busy", busy, 0);
    checkOutput("ab_valid_addr", rom_addr, 0);
    checkOutput("ab_valid_done", done, 0);
    buildExpected(0, 1);
    runUntilDone(0, 100, 200);

    // No end marker at the top of the address space.
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom[0] = ent(0, 'h0FF); rom[62] = ent(0, 'h1AB); rom[63] = ent(1, 'h0CD);
    buildExpected(62, 1);
    runUntilDone(62, 100, 200);
    checkOutput("top_no_wrap_addr", rom_addr, 63);

    // Randomized sequences with random backpressure.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 64; i++) rom[i] = '0;
      base = $urandom_range(20, 50);
      len  = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) rom[base + i] = ent($urandom_range(0, 3), $urandom_range(1, 511));
      rom[base + len] = ent($urandom_range(0, 15), 0);
      buildExpected(base, 1);
      runUntilDone(base, 60, 800);
    end

    // Async reset in the middle of VALID, then first-valid latency for both ROM latencies.
    loadTest1();
    abortAll();
    applyStimulus(1, 0, 0, 0, 0);
    k = 0;
    while (!data_valid && k < 10) begin applyStimulus(0, 0, 0, 0, 0); k++; end
    checkOutput("rst_mid_valid_reached", data_valid, 1);
    @(posedge clk);
    #2 restn_i = 0;
    #1;
    checkOutput("arst_addr", rom_addr, 0);
    checkOutput("arst_data", data, 0);
    checkOutput("arst_valid", data_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_valid2", data_valid2, 0);
    @(negedge clk);
    restn_i = 1; start_i = 1; base_addr_i = 0; ready_i = 0;
    first1 = -1; first2 = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start_i = 0;
      if (data_valid && first1 < 0) first1 = i;
      if (data_valid2 && first2 < 0) first2 = i;
    end
    checkOutput("first_valid_lat1", first1, 3);
    checkOutput("first_valid_lat2", first2, 4);
    abortAll();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
